// File: rtl/pio_loader.sv
// Loads a program into one PIO state machine, then sets wrap end, divider, pin groups and enables, issuing one action per clock.
// The first action appears two clocks after start. There is no backpressure: pio accepts an action every cycle, and abort cancels the sequence.
module pio_loader #(
  parameter int NUM_SM   = 4,
  parameter int MAX_PROG = 32,
  localparam int MW = $clog2(NUM_SM),
  localparam int AW = $clog2(MAX_PROG)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [AW:0]       cfg_len,
  input  logic [MW-1:0]     cfg_mindex,
  input  logic [23:0]       cfg_div,
  input  logic [31:0]       cfg_pin_grps,
  input  logic [NUM_SM-1:0] cfg_en,
  output logic [AW-1:0]     prog_addr,
  input  logic [15:0]       prog_data,
  output logic [3:0]        action,
  output logic [AW-1:0]     index,
  output logic [MW-1:0]     mindex,
  output logic [31:0]       din,
  output logic              busy,
  output logic              done
);

  localparam logic [3:0] ACT_NONE  = 4'd0;
  localparam logic [3:0] ACT_INSTR = 4'd1;
  localparam logic [3:0] ACT_PEND  = 4'd2;
  localparam logic [3:0] ACT_GRPS  = 4'd5;
  localparam logic [3:0] ACT_EN    = 4'd6;
  localparam logic [3:0] ACT_DIV   = 4'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_INSTR, S_PEND, S_DIV, S_GRPS, S_EN, S_FIN
  } state_t;

  state_t            state;
  logic [AW:0]       len_q;
  logic [23:0]       div_q;
  logic [31:0]       grps_q;
  logic [NUM_SM-1:0] en_q;
  logic [AW-1:0]     icnt;
  logic [AW:0]       len_c;
  logic [AW-1:0]     last_addr;

  assign len_c     = (cfg_len > (AW+1)'(MAX_PROG)) ? (AW+1)'(MAX_PROG) : cfg_len;
  assign last_addr = AW'(len_q - 1'b1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      action    <= ACT_NONE;
      index     <= '0;
      mindex    <= '0;
      din       <= '0;
      prog_addr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      len_q     <= '0;
      div_q     <= '0;
      grps_q    <= '0;
      en_q      <= '0;
      icnt      <= '0;
    end else if (state != S_IDLE && abort) begin
      // Already-issued actions stay in effect; we only stop issuing more.
      action <= ACT_NONE;
      busy   <= 1'b0;
      done   <= 1'b0;
      state  <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start && !abort) begin
            busy      <= 1'b1;
            prog_addr <= '0;
            icnt      <= '0;
            mindex    <= cfg_mindex;
            len_q     <= len_c;
            div_q     <= cfg_div;
            grps_q    <= cfg_pin_grps;
            en_q      <= cfg_en;
            state     <= (len_c == '0) ? S_DIV : S_FETCH;
          end
        end
        S_FETCH: begin
          if (prog_addr != last_addr) prog_addr <= prog_addr + 1'b1;
          state <= S_INSTR;
        end
        S_INSTR: begin
          // Memory read runs one address ahead of the slot being written.
          action <= ACT_INSTR;
          index  <= icnt;
          din    <= {16'b0, prog_data};
          icnt   <= icnt + 1'b1;
          if (prog_addr != last_addr) prog_addr <= prog_addr + 1'b1;
          if (icnt == last_addr) state <= S_PEND;
        end
        S_PEND: begin
          action <= ACT_PEND;
          din    <= 32'(last_addr);
          state  <= S_DIV;
        end
        S_DIV: begin
          action <= ACT_DIV;
          din    <= 32'(div_q);
          state  <= S_GRPS;
        end
        S_GRPS: begin
          action <= ACT_GRPS;
          din    <= grps_q;
          state  <= S_EN;
        end
        S_EN: begin
          action <= ACT_EN;
          din    <= 32'(en_q);
          state  <= S_FIN;
        end
        S_FIN: begin
          action <= ACT_NONE;
          din    <= '0;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pio_loader.sv
// Directed bench for pio_loader: drives load sequences against a registered program memory and checks every action cycle.
module tb_pio_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [5:0]  cfg_len = '0;
  logic [1:0]  cfg_mindex = '0;
  logic [23:0] cfg_div = '0;
  logic [31:0] cfg_pin_grps = '0;
  logic [3:0]  cfg_en = '0;
  logic [4:0]  prog_addr;
  logic [15:0] prog_data = '0;
  logic [3:0]  action;
  logic [4:0]  index;
  logic [1:0]  mindex;
  logic [31:0] din;
  logic        busy;
  logic        done;

  logic [15:0] mem [32];
  int n_checks = 0;
  int n_fail   = 0;

  pio_loader dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .cfg_len(cfg_len), .cfg_mindex(cfg_mindex), .cfg_div(cfg_div),
    .cfg_pin_grps(cfg_pin_grps), .cfg_en(cfg_en), .prog_addr(prog_addr),
    .prog_data(prog_data), .action(action), .index(index), .mindex(mindex),
    .din(din), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) prog_data <= mem[prog_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    n_checks++;
    if ({action, index, mindex, din, prog_addr, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got act=%0d idx=%0d mi=%0d din=%h pa=%0d busy=%b done=%b want all zero",
               action, index, mindex, din, prog_addr, busy, done);
    end
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0 || action !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_idle got busy=%b act=%0d want busy=0 act=0", busy, action);
    end
  endtask

  // Full sequence; cfg inputs are scrambled after the start edge and start is
  // optionally re-pulsed at edge rp to confirm both are ignored while busy.
  task automatic test_sequence(input string name, input int len_raw, input logic [1:0] mi,
                               input logic [23:0] dv, input logic [31:0] gp,
                               input logic [3:0] en, input int rp);
    int L, p, ei;
    logic [3:0] ea;
    logic [31:0] ed;
    logic [4:0] epa;
    logic chk_d, chk_i, eb, edn;
    L = (len_raw > 32) ? 32 : len_raw;
    cfg_len = 6'(len_raw); cfg_mindex = mi; cfg_div = dv; cfg_pin_grps = gp; cfg_en = en;
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_len = 6'd7; cfg_mindex = ~mi; cfg_div = ~dv; cfg_pin_grps = ~gp; cfg_en = ~en;
    n_checks++;
    if (busy !== 1'b1 || prog_addr !== 5'd0 || action !== 4'd0) begin
      n_fail++;
      $display("FAIL %s E0 got busy=%b pa=%0d act=%0d want busy=1 pa=0 act=0", name, busy, prog_addr, action);
    end
    for (int e = 1; e <= L + 7; e++) begin
      if (e == rp) start = 1'b1;
      tick();
      start = 1'b0;
      p = (L == 0) ? e + 2 : e;
      ea = 4'd0; ed = '0; chk_d = 1'b0; chk_i = 1'b0; ei = 0;
      if (L > 0 && e >= 2 && e <= L + 1) begin
        ea = 4'd1; ei = e - 2; ed = {16'b0, mem[e-2]}; chk_d = 1'b1; chk_i = 1'b1;
      end else if (L > 0 && p == L + 2) begin
        ea = 4'd2; ed = 32'(L - 1); chk_d = 1'b1;
      end else if (p == L + 3) begin
        ea = 4'd7; ed = {8'b0, dv}; chk_d = 1'b1;
      end else if (p == L + 4) begin
        ea = 4'd5; ed = gp; chk_d = 1'b1;
      end else if (p == L + 5) begin
        ea = 4'd6; ed = {28'b0, en}; chk_d = 1'b1;
      end else if (p >= L + 6) begin
        ed = '0; chk_d = 1'b1;
      end
      if (L > 0 && e >= L + 2) begin
        chk_i = 1'b1; ei = L - 1;
      end
      eb  = (p <= L + 5);
      edn = (p == L + 6);
      epa = (L == 0) ? 5'd0 : 5'((e < L - 1) ? e : L - 1);
      n_checks++;
      if (action !== ea || busy !== eb || done !== edn || mindex !== mi || prog_addr !== epa) begin
        n_fail++;
        $display("FAIL %s E%0d ctl got act=%0d busy=%b done=%b mi=%0d pa=%0d want act=%0d busy=%b done=%b mi=%0d pa=%0d",
                 name, e, action, busy, done, mindex, prog_addr, ea, eb, edn, mi, epa);
      end
      if (chk_d) begin
        n_checks++;
        if (din !== ed) begin
          n_fail++;
          $display("FAIL %s E%0d din got %h want %h", name, e, din, ed);
        end
      end
      if (chk_i) begin
        n_checks++;
        if (index !== 5'(ei)) begin
          n_fail++;
          $display("FAIL %s E%0d index got %0d want %0d", name, e, index, ei);
        end
      end
    end
  endtask

  task automatic test_abort();
    cfg_len = 6'd10; cfg_mindex = 2'd1; cfg_div = 24'h000100; cfg_pin_grps = 32'h1; cfg_en = 4'h2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 7; e++) tick();
    n_checks++;
    if (action !== 4'd1 || index !== 5'd5) begin
      n_fail++;
      $display("FAIL abort_pre got act=%0d idx=%0d want act=1 idx=5", action, index);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if (action !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || index !== 5'd5) begin
      n_fail++;
      $display("FAIL abort_next got act=%0d busy=%b done=%b idx=%0d want act=0 busy=0 done=0 idx=5",
               action, busy, done, index);
    end
    for (int e = 0; e < 12; e++) begin
      tick();
      n_checks++;
      if (action !== 4'd0 || done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_quiet cyc%0d got act=%0d done=%b busy=%b want 0 0 0", e, action, done, busy);
      end
    end
  endtask

  task automatic test_start_abort_idle();
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    for (int e = 0; e < 4; e++) begin
      n_checks++;
      if (busy !== 1'b0 || action !== 4'd0) begin
        n_fail++;
        $display("FAIL start_abort_idle cyc%0d got busy=%b act=%0d want busy=0 act=0", e, busy, action);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    cfg_len = 6'd4; cfg_mindex = 2'd2; cfg_div = 24'h012345; cfg_pin_grps = 32'hDEADBEEF; cfg_en = 4'hF;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 7; e++) tick();
    n_checks++;
    if (action !== 4'd7 || din !== 32'h00012345) begin
      n_fail++;
      $display("FAIL rstmid_div got act=%0d din=%h want act=7 din=00012345", action, din);
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({action, index, mindex, din, prog_addr, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_async got act=%0d idx=%0d mi=%0d din=%h pa=%0d busy=%b done=%b want all zero",
               action, index, mindex, din, prog_addr, busy, done);
    end
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    n_checks++;
    if (busy !== 1'b0 || action !== 4'd0) begin
      n_fail++;
      $display("FAIL rstmid_nostart got busy=%b act=%0d want busy=0 act=0", busy, action);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 16'hA000 + 16'(i * 37);
    test_reset();
    mem[0] = 16'hE081; mem[1] = 16'hE001;
    test_sequence("basic_l2", 2, 2'd0, 24'h000280, 32'h04000000, 4'b0001, -1);
    for (int i = 0; i < 32; i++) mem[i] = 16'h5000 ^ 16'(i * 613);
    test_sequence("full_l32", 32, 2'd3, 24'h00ABCD, 32'h0F0F0F0F, 4'b1000, -1);
    test_sequence("len0", 0, 2'd1, 24'h123456, 32'h89ABCDEF, 4'b0101, -1);
    test_sequence("clamp_l50", 50, 2'd2, 24'hFFFFFF, 32'hFFFFFFFF, 4'b1111, -1);
    test_abort();
    test_start_abort_idle();
    test_sequence("restart_ignored", 5, 2'd1, 24'h000300, 32'h00000011, 4'b0011, 3);
    test_reset_mid();
    test_sequence("after_reset", 3, 2'd2, 24'h000180, 32'h00F00000, 4'b0110, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
